ddr2_req_queue: RTL
===================

// Module: ddr2_req_queue
// PURPOSE
//  Front-end request queue feeding the DDR2 controller's client port. Accepts read/write requests
//  from user logic on a valid/ready interface and buffers them in a FIFO. Issues one request at a time,
//  holding c_rd_req/c_wr_req stable until c_ack, and returns read data as a one-cycle response pulse.
//  A watchdog flags a controller that never acknowledges.
// PARAMETERS
//  DEPTH        4     request FIFO entries (power of 2, >=2)
//  TIMEOUT      4096  cycles from issue to c_ack before error; 0 disables watchdog
// PORTS
//  clk          in   1   system clock (same clock as controller)
//  rst_n        in   1   synchronous, active-low reset
//  req_valid    in   1   user request present
//  req_ready    out  1   FIFO not full
//  req_we       in   1   1=write, 0=read
//  req_addr     in   26  {row[25:13], bank[12:10], col[9:0]}
//  req_wdata    in   64  write data (ignored for reads)
//  rsp_valid    out  1   one-cycle pulse: read data valid
//  rsp_rdata    out  64  read data, held until next rsp_valid
//  wr_done      out  1   one-cycle pulse: write accepted by controller
//  busy         out  1   FIFO non-empty or request in flight
//  err_timeout  out  1   sticky watchdog error
//  c_addr       out  26  to controller
//  c_data_in    out  64  to controller
//  c_rd_req     out  1   to controller
//  c_wr_req     out  1   to controller
//  c_rdy        in   1   controller idle
//  c_ack        in   1   controller acknowledge (1-cycle pulse)
//  c_data_out   in   64  controller read data, valid with c_ack
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FIFO emptied; state IDLE; all outputs 0 except req_ready=1.
//  Enqueue on req_valid&&req_ready: push {we,addr,wdata}. Push while full: impossible (ready=0).
//  Simultaneous push+pop while full: pop frees slot the NEXT cycle (req_ready from registered count).
//  FSM (registered):
//   IDLE  : FIFO non-empty && c_rdy -> pop head into issue regs, go ISSUE. c_rdy=0 -> stay (refresh/precharge).
//   ISSUE : c_addr/c_data_in from issue regs; c_rd_req=~we, c_wr_req=we, both stable every cycle.
//           c_ack=1 -> drop req same-edge (req low next cycle); read: rsp_rdata<=c_data_out, rsp_valid=1;
//           write: wr_done=1; go DRAIN. Watchdog count reaches TIMEOUT -> err_timeout<=1, drop req, go DRAIN.
//   DRAIN : wait c_rdy==0 seen or 1 cycle elapsed, then require c_rdy==1 -> IDLE (prevents re-issue while
//           controller still precharging).
//  c_rd_req and c_wr_req are never both 1; never asserted outside ISSUE.
//  Issue latency: request into empty FIFO with c_rdy=1 -> c_*_req high 2 cycles after accept.
//  Order: strictly FIFO; responses return in request order; one outstanding request max.
//  Watchdog: counter cleared on entering ISSUE, increments each ISSUE cycle; err_timeout cleared only by reset;
//  a timed-out read produces no rsp_valid. Late c_ack outside ISSUE is ignored.
//  c_ack coinciding with TIMEOUT: ack wins, no error.
//  FIFO pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
// STRUCTURE
//  ddr2_ctrl_defs.vh: C_ADDR_W=26, C_DATA_W=64, FSM encodings QS_IDLE/QS_ISSUE/QS_DRAIN.
//  Sub-module ddr2_sync_fifo (WIDTH=91, DEPTH): registered pointers/count, full/empty, no fall-through.
// TESTING
//  1 Reset: rst_n=0 3 cycles mid-ISSUE -> c_rd_req=c_wr_req=0, req_ready=1, busy=0 next cycle.
//  2 Write: addr=26'h2A5_5001, wdata=64'hDEAD_BEEF_0123_4567, c_rdy=1 -> c_wr_req held until c_ack, wr_done 1 cycle.
//  3 Read: addr=26'h000_0400, model returns 64'h1122_3344_5566_7788 with c_ack -> rsp_valid 1 cycle, rsp_rdata matches.
//  4 Fill: 5 back-to-back pushes with c_rdy=0 -> req_ready=0 after 4th; release c_rdy -> 4 issued in order.
//  5 Refresh stall: c_rdy=0 for 50 cycles while queued -> no req asserted until c_rdy=1.
//  6 Timeout: TIMEOUT=16, never ack -> err_timeout=1 at cycle 16 of ISSUE, req dropped, next entry issued.

Source files
------------

// File: rtl/ddr2_req_queue_pkg.sv
// Shared types for the DDR2 request queue: bus widths, queue FSM states,
// the buffered request record and the watchdog counter sizing helper.
// Imported by the interface, the FIFO user and the top level.
package ddr2_req_queue_pkg;

    localparam int C_ADDR_W = 26;   // {row[25:13], bank[12:10], col[9:0]}
    localparam int C_DATA_W = 64;

    typedef enum logic [1:0] {
        QS_IDLE  = 2'd0,
        QS_ISSUE = 2'd1,
        QS_DRAIN = 2'd2
    } qstate_t;

    // One buffered request; 91 bits wide.
    typedef struct packed {
        logic                we;
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] wdata;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Watchdog counter only has to hold 0..timeout-1.
    function automatic int wd_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ddr2_req_queue_if.sv
// Request/response and controller-side signal bundle of the DDR2 request queue.
// slave  : the queue itself (accepts user requests, drives the controller client port).
// master : the surroundings (user logic plus DDR2 controller).
interface ddr2_req_queue_if;
    import ddr2_req_queue_pkg::*;

    // user side
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [C_ADDR_W-1:0] req_addr;
    logic [C_DATA_W-1:0] req_wdata;
    logic                rsp_valid;
    logic [C_DATA_W-1:0] rsp_rdata;
    logic                wr_done;

    // controller client port
    logic [C_ADDR_W-1:0] c_addr;
    logic [C_DATA_W-1:0] c_data_in;
    logic                c_rd_req;
    logic                c_wr_req;
    logic                c_rdy;
    logic                c_ack;
    logic [C_DATA_W-1:0] c_data_out;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, wr_done,
        output c_addr, c_data_in, c_rd_req, c_wr_req,
        input  c_rdy, c_ack, c_data_out
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_done,
        input  c_addr, c_data_in, c_rd_req, c_wr_req,
        output c_rdy, c_ack, c_data_out
    );

endinterface

// File: rtl/ddr2_sync_fifo.sv
// Purpose : synchronous FIFO, registered pointers and count, no fall-through.
// Latency : a push is visible at rdata/empty one cycle later; rdata shows the head while !empty.
// Backpr. : full from the registered count; push while full and pop while empty are ignored.
// Ports   : clk, rst_n (sync, active-low), push/wdata, pop/rdata, full, empty.
module ddr2_sync_fifo #(
    parameter int WIDTH = 91,
    parameter int DEPTH = 4     // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ddr2_req_queue.sv
// Purpose : buffers user read/write requests and issues them one at a time to the DDR2 controller.
// Latency : request into empty queue with c_rdy=1 -> c_*_req high 2 cycles after accept; response 1 cycle after c_ack.
// Backpr. : req_ready = FIFO not full (registered count); issue waits for c_rdy; one request outstanding.
// Ports   : clk, rst_n (sync, active-low); bus (slave modport: user req/rsp + controller client port);
//           busy (queue non-empty or request in flight); err_timeout (sticky watchdog error).
module ddr2_req_queue
    import ddr2_req_queue_pkg::*;
#(
    parameter int DEPTH   = 4,      // power of 2, >= 2
    parameter int TIMEOUT = 4096    // ISSUE cycles without c_ack before error; 0 disables
) (
    input  logic            clk,
    input  logic            rst_n,
    ddr2_req_queue_if.slave bus,
    output logic            busy,
    output logic            err_timeout
);

    localparam int             WD_W    = wd_width(TIMEOUT);
    localparam bit             WD_EN   = (TIMEOUT != 0);
    // The counter holds the number of completed ISSUE cycles, so the last
    // allowed cycle is the one entered with TIMEOUT-1 already counted.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    qstate_t          state;
    qstate_t          state_nxt;
    req_t             head;
    req_t             iss;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_hit;
    logic             drain_seen;
    logic             rsp_valid_q;
    logic             wr_done_q;
    logic [C_DATA_W-1:0] rsp_rdata_q;
    logic             err_q;
    logic             rd_req;
    logic             wr_req;

    // ------------------------------------------------------------------
    // Request buffer
    // ------------------------------------------------------------------
    assign fifo_push = bus.req_valid && bus.req_ready;

    ddr2_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({bus.req_we, bus.req_addr, bus.req_wdata}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wd_hit = WD_EN && (wd_cnt == WD_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= QS_IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            QS_IDLE:  if (!fifo_empty && bus.c_rdy) state_nxt = QS_ISSUE;
            // An ack in the last watchdog cycle still completes normally.
            QS_ISSUE: if (bus.c_ack || wd_hit)      state_nxt = QS_DRAIN;
            // Spend at least one cycle here so a c_rdy that has not yet fallen
            // after the ack cannot trigger an immediate re-issue.
            QS_DRAIN: if (drain_seen && bus.c_rdy)  state_nxt = QS_IDLE;
            default:                                state_nxt = QS_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        fifo_pop = 1'b0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        busy     = !fifo_empty || (state != QS_IDLE);
        case (state)
            QS_IDLE:  fifo_pop = !fifo_empty && bus.c_rdy;
            QS_ISSUE: begin
                rd_req = !iss.we;
                wr_req =  iss.we;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue registers, watchdog and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss         <= '0;
            wd_cnt      <= '0;
            drain_seen  <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            drain_seen  <= (state == QS_DRAIN);

            if (fifo_pop) begin
                iss    <= head;
                wd_cnt <= '0;
            end

            // c_ack is only meaningful while a request is presented.
            if (state == QS_ISSUE) begin
                if (bus.c_ack) begin
                    if (iss.we) begin
                        wr_done_q <= 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= bus.c_data_out;
                    end
                end else if (wd_hit) begin
                    err_q <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.c_addr    = iss.addr;
    assign bus.c_data_in = iss.wdata;
    assign bus.c_rd_req  = rd_req;
    assign bus.c_wr_req  = wr_req;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.wr_done   = wr_done_q;
    assign err_timeout   = err_q;

endmodule
